// File: rtl/stream_to_blocks.sv
// stream_to_blocks: converts a raster stream of binary pixels into
// blk_w x blk_h blocks. Pixels are packed into blk_w-bit words and written
// into one of two ping-pong strip buffers. Once a strip is complete, the
// read side fetches one block column at a time, one row word per cycle,
// and presents the assembled block with a valid/ready handshake.
module stream_to_blocks #(
  parameter int blk_w    = 16,
  parameter int blk_h    = 16,
  parameter int frame_w  = 240,
  parameter int blk_size = blk_w * blk_h
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                pix_in,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  output logic [blk_size-1:0]                 blk_data,
  output logic [$clog2(frame_w/blk_w)-1:0]    blk_col,
  output logic                                blk_last,
  output logic                                blk_valid,
  input  logic                                blk_ready
);

  localparam int n_cols = frame_w / blk_w;
  localparam int col_w  = $clog2(n_cols);
  localparam int row_w  = (blk_h > 1) ? $clog2(blk_h) : 1;
  localparam int bit_w  = (blk_w > 1) ? $clog2(blk_w) : 1;
  localparam int lin_w  = $clog2(blk_h * n_cols);
  localparam int depth  = 2 ** (lin_w + 1);

  localparam logic [col_w-1:0] last_col  = col_w'(n_cols - 1);
  localparam logic [row_w-1:0] last_row  = row_w'(blk_h - 1);
  localparam logic [bit_w-1:0] last_bit  = bit_w'(blk_w - 1);
  localparam logic [row_w:0]   fetch_end = (row_w + 1)'(blk_h);

  localparam logic [1:0] st_idle    = 2'd0;
  localparam logic [1:0] st_fetch   = 2'd1;
  localparam logic [1:0] st_present = 2'd2;

  // ---------------------------------------------------------------- write side
  logic [blk_w-1:0] shift_reg;
  logic [bit_w-1:0] bit_cnt_reg;
  logic [col_w-1:0] wr_col_reg;
  logic [row_w-1:0] wr_row_reg;
  logic [1:0]       wr_cnt_reg;
  logic [1:0]       rd_cnt_reg;

  logic             full;
  logic             pix_accept;
  logic             wr_en;
  logic [blk_w-1:0] wr_word;
  logic [lin_w-1:0] wr_lin;
  logic [lin_w:0]   wr_addr;

  // Two complete strips outstanding means both buffers hold unread data.
  assign full       = (wr_cnt_reg - rd_cnt_reg) == 2'd2;
  assign pix_ready  = reset_n && !full;
  assign pix_accept = pix_valid && pix_ready;

  // New pixel enters at the MSB so the first pixel of a word ends up at bit 0.
  assign wr_word = {pix_in, shift_reg[blk_w-1:1]};
  assign wr_en   = pix_accept && (bit_cnt_reg == last_bit);
  assign wr_lin  = lin_w'(wr_row_reg * n_cols) + lin_w'(wr_col_reg);
  // The low bit of the strip counter selects the ping-pong buffer.
  assign wr_addr = {wr_cnt_reg[0], wr_lin};

  // Pixel packing plus write column/row/strip position tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      wr_col_reg  <= '0;
      wr_row_reg  <= '0;
      wr_cnt_reg  <= '0;
    end else if (pix_accept) begin
      shift_reg <= wr_word;
      if (bit_cnt_reg == last_bit) begin
        bit_cnt_reg <= '0;
        if (wr_col_reg == last_col) begin
          wr_col_reg <= '0;
          if (wr_row_reg == last_row) begin
            wr_row_reg <= '0;
            wr_cnt_reg <= wr_cnt_reg + 2'd1;
          end else begin
            wr_row_reg <= wr_row_reg + 1'b1;
          end
        end else begin
          wr_col_reg <= wr_col_reg + 1'b1;
        end
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- strip RAM
  logic [blk_w-1:0] mem_reg [depth];
  logic [blk_w-1:0] rd_data_reg;
  logic             rd_en;
  logic [lin_w-1:0] rd_lin;
  logic [lin_w:0]   rd_addr;

  // Simple dual-port buffer: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_word;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  // ---------------------------------------------------------------- read side
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [col_w-1:0] rd_col_reg;
  logic [row_w:0]   fetch_cnt_reg;
  logic             cap_valid_reg;
  logic [row_w-1:0] cap_row_reg;
  logic [blk_w-1:0] blk_rows_reg [blk_h];
  logic             fetch_done;
  logic             handshake;

  assign fetch_done = (fetch_cnt_reg == fetch_end);
  assign rd_en      = (state_reg == st_fetch) && !fetch_done;
  assign rd_lin     = lin_w'(fetch_cnt_reg[row_w-1:0] * n_cols) + lin_w'(rd_col_reg);
  assign rd_addr    = {rd_cnt_reg[0], rd_lin};
  assign handshake  = (state_reg == st_present) && blk_ready;

  // Read FSM next-state: wait for a full strip, fetch a column, present it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      st_idle:    if (rd_cnt_reg != wr_cnt_reg) state_next = st_fetch;
      st_fetch:   if (fetch_done) state_next = st_present;
      st_present: if (blk_ready) state_next = (rd_col_reg == last_col) ? st_idle : st_fetch;
      default:    state_next = st_idle;
    endcase
  end

  // Read FSM state, fetch sequencing, column and strip-consumed tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= st_idle;
      rd_col_reg    <= '0;
      fetch_cnt_reg <= '0;
      cap_valid_reg <= 1'b0;
      cap_row_reg   <= '0;
      rd_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      // Read data arrives one cycle after issue; remember which row it is.
      cap_valid_reg <= rd_en;
      cap_row_reg   <= fetch_cnt_reg[row_w-1:0];
      if (rd_en) begin
        fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
      end
      if (handshake) begin
        fetch_cnt_reg <= '0;
        if (rd_col_reg == last_col) begin
          rd_col_reg <= '0;
          rd_cnt_reg <= rd_cnt_reg + 2'd1;
        end else begin
          rd_col_reg <= rd_col_reg + 1'b1;
        end
      end
    end
  end

  // One holding register per block row, loaded from the RAM output word.
  genvar gi;
  generate
    for (gi = 0; gi < blk_h; gi++) begin : g_row
      // Capture the returning read word into its row slot.
      always_ff @(posedge clk) begin
        if (cap_valid_reg && (cap_row_reg == row_w'(gi))) begin
          blk_rows_reg[gi] <= rd_data_reg;
        end
      end
      assign blk_data[gi*blk_w +: blk_w] = blk_rows_reg[gi];
    end
  endgenerate

  assign blk_valid = (state_reg == st_present);
  assign blk_col   = rd_col_reg;
  assign blk_last  = blk_valid && (rd_col_reg == last_col);

endmodule

// File: tb/tb_stream_to_blocks.sv
// Testbench for stream_to_blocks: drives pixel strips and compares every
// emitted block with a strip-image reference model.
module tb_stream_to_blocks;

  localparam int BW = 16;
  localparam int BH = 16;
  localparam int FW = 240;
  localparam int NC = FW / BW;
  localparam int SP = FW * BH;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [255:0] blk_data;
  logic [3:0]   blk_col;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;

  always #5 clk = ~clk;

  stream_to_blocks dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .blk_data  (blk_data),
    .blk_col   (blk_col),
    .blk_last  (blk_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready)
  );

  typedef struct {
    logic [255:0] data;
    logic [3:0]   col;
    logic         last;
  } blk_t;

  // reference model: current strip image, expected blocks, strip counts
  bit   img [BH][FW];
  blk_t expq [$];
  int   pix_cnt, strips_done, strips_consumed, acc_total;
  int   cyc, last_acc_cyc;
  int   checks, errors;

  // per-cycle samples
  logic         s_ready, s_valid, s_last, s_hs, s_exp_ok, s_exp_ready;
  logic [255:0] s_data;
  logic [3:0]   s_col;
  blk_t         s_exp;
  int           s_cyc;

  // One clock cycle: drive inputs, sample outputs, advance the model.
  task automatic step(input bit pv, input bit pin, input bit br);
    pix_valid = pv;
    pix_in    = pin;
    blk_ready = br;
    #1;
    s_ready     = pix_ready;
    s_valid     = blk_valid;
    s_data      = blk_data;
    s_col       = blk_col;
    s_last      = blk_last;
    s_cyc       = cyc;
    s_exp_ready = reset_n && ((strips_done - strips_consumed) < 2);
    s_hs        = blk_valid && br && reset_n;
    s_exp_ok    = 1'b0;
    if (s_hs && expq.size() > 0) begin
      s_exp    = expq.pop_front();
      s_exp_ok = 1'b1;
      if (s_exp.last) strips_consumed++;
    end
    if (pv && pix_ready && reset_n) begin
      img[pix_cnt / FW][pix_cnt % FW] = pin;
      pix_cnt++;
      acc_total++;
      last_acc_cyc = cyc;
      if (pix_cnt == SP) begin
        for (int c = 0; c < NC; c++) begin
          blk_t b;
          b.data = '0;
          for (int r = 0; r < BH; r++)
            for (int k = 0; k < BW; k++)
              b.data[r*BW + k] = img[r][c*BW + k];
          b.col  = 4'(c);
          b.last = (c == NC - 1);
          expq.push_back(b);
        end
        strips_done++;
        pix_cnt = 0;
      end
    end
    if (!reset_n) begin
      expq.delete();
      pix_cnt = 0; strips_done = 0; strips_consumed = 0; acc_total = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) step(0, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b required 0", s_ready); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid: got %b required 0", s_valid); end
    checks++; if (s_col !== 4'd0) begin errors++; $display("FAIL reset_blk_col: got %0d required 0", s_col); end
    checks++; if (s_last !== 1'b0) begin errors++; $display("FAIL reset_blk_last: got %b required 0", s_last); end
    reset_n = 1'b1;
    step(0, 0, 1);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", s_ready); end
  endtask

  task automatic test_checker_strip();
    int hs = 0;
    int prev_hs = 0;
    logic [255:0] pat;
    for (int r = 0; r < BH; r++) pat[r*BW +: BW] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
    do_reset(2);
    for (int t = 0; t < SP + 1000 && hs < NC; t++) begin
      int p = acc_total;
      step(acc_total < SP, 1'(((p % FW) + (p / FW)) % 2), 1);
      checks++; if (s_ready !== s_exp_ready) begin errors++; $display("FAIL checker_pix_ready: cycle %0d got %b required %b", s_cyc, s_ready, s_exp_ready); end
      if (s_hs) begin
        checks++;
        if (!s_exp_ok) begin errors++; $display("FAIL checker_extra_block: got col %0d required none", s_col); end
        else if (s_data !== s_exp.data || s_col !== s_exp.col || s_last !== s_exp.last) begin
          errors++; $display("FAIL checker_block: got col %0d last %b data %h required col %0d last %b data %h", s_col, s_last, s_data, s_exp.col, s_exp.last, s_exp.data);
        end
        checks++; if (s_data !== pat) begin errors++; $display("FAIL checker_pattern: col %0d got %h required %h", s_col, s_data, pat); end
        if (hs == 0) begin
          checks++; if (s_cyc - last_acc_cyc !== BH + 3) begin errors++; $display("FAIL checker_first_latency: got %0d required %0d", s_cyc - last_acc_cyc, BH + 3); end
        end else begin
          checks++; if (s_cyc - prev_hs !== BH + 2) begin errors++; $display("FAIL checker_block_gap: got %0d required %0d", s_cyc - prev_hs, BH + 2); end
        end
        prev_hs = s_cyc;
        hs++;
      end
    end
    checks++; if (hs !== NC) begin errors++; $display("FAIL checker_block_count: got %0d required %0d", hs, NC); end
  endtask

  task automatic test_single_pixel();
    int hs = 0;
    do_reset(2);
    for (int t = 0; t < SP + 1000 && hs < NC; t++) begin
      int p = acc_total;
      step(acc_total < SP, 1'((p % FW) == 37 && (p / FW) == 5), 1);
      checks++; if (s_ready !== s_exp_ready) begin errors++; $display("FAIL single_pix_ready: cycle %0d got %b required %b", s_cyc, s_ready, s_exp_ready); end
      if (s_hs) begin
        checks++;
        if (!s_exp_ok) begin errors++; $display("FAIL single_extra_block: got col %0d required none", s_col); end
        else if (s_data !== s_exp.data || s_col !== s_exp.col || s_last !== s_exp.last) begin
          errors++; $display("FAIL single_block: got col %0d last %b data %h required col %0d last %b data %h", s_col, s_last, s_data, s_exp.col, s_exp.last, s_exp.data);
        end
        checks++; if ((s_data != '0) !== (s_col == 4'd2)) begin errors++; $display("FAIL single_nonzero: col %0d got data %h required nonzero only at col 2", s_col, s_data); end
        if (s_col == 4'd2) begin
          checks++; if (s_data[5*16+5] !== 1'b1) begin errors++; $display("FAIL single_bit: got %b required 1", s_data[5*16+5]); end
        end
        hs++;
      end
    end
    checks++; if (hs !== NC) begin errors++; $display("FAIL single_block_count: got %0d required %0d", hs, NC); end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    logic [255:0] held;
    bit have_held = 0;
    do_reset(2);
    for (int t = 0; t < 2 * SP + 300; t++) begin
      step(acc_total < 3 * SP, 1'($urandom), 0);
      checks++; if (s_ready !== s_exp_ready) begin errors++; $display("FAIL bp_pix_ready: cycle %0d got %b required %b", s_cyc, s_ready, s_exp_ready); end
      if (s_valid) begin
        if (!have_held) begin held = s_data; have_held = 1; end
        else if (t % 64 == 0) begin
          checks++; if (s_data !== held || s_col !== 4'd0) begin errors++; $display("FAIL bp_hold: got col %0d data %h required col 0 data %h", s_col, s_data, held); end
        end
      end
    end
    checks++; if (acc_total !== 2 * SP) begin errors++; $display("FAIL bp_accepted: got %0d required %0d", acc_total, 2 * SP); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", s_ready); end
    checks++; if (!have_held || expq.size() == 0 || held !== expq[0].data) begin errors++; $display("FAIL bp_block0: got %h (seen %b) required first model block", held, have_held); end
    for (int t = 0; t < 2 * SP && hs < 3 * NC; t++) begin
      step(acc_total < 3 * SP, 1'($urandom), 1);
      checks++; if (s_ready !== s_exp_ready) begin errors++; $display("FAIL bp_drain_ready: cycle %0d got %b required %b", s_cyc, s_ready, s_exp_ready); end
      if (s_hs) begin
        checks++;
        if (!s_exp_ok) begin errors++; $display("FAIL bp_extra_block: got col %0d required none", s_col); end
        else if (s_data !== s_exp.data || s_col !== s_exp.col || s_last !== s_exp.last) begin
          errors++; $display("FAIL bp_block: got col %0d last %b data %h required col %0d last %b data %h", s_col, s_last, s_data, s_exp.col, s_exp.last, s_exp.data);
        end
        hs++;
      end
    end
    checks++; if (hs !== 3 * NC || expq.size() != 0) begin errors++; $display("FAIL bp_block_count: got %0d left %0d required %0d left 0", hs, expq.size(), 3 * NC); end
  endtask

  task automatic test_random();
    int hs = 0;
    bit prev_hold = 0;
    logic [255:0] prev_data;
    logic [3:0] prev_col;
    logic prev_last;
    do_reset(2);
    for (int t = 0; t < 45000 && hs < 4 * NC; t++) begin
      bit br = 1'($urandom);
      step((acc_total < 4 * SP) && 1'($urandom), 1'($urandom), br);
      checks++; if (s_ready !== s_exp_ready) begin errors++; $display("FAIL rand_pix_ready: cycle %0d got %b required %b", s_cyc, s_ready, s_exp_ready); end
      if (prev_hold) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== prev_data || s_col !== prev_col || s_last !== prev_last) begin
          errors++; $display("FAIL rand_hold: cycle %0d got valid %b col %0d data %h required valid 1 col %0d data %h", s_cyc, s_valid, s_col, s_data, prev_col, prev_data);
        end
      end
      prev_hold = s_valid && !br;
      prev_data = s_data; prev_col = s_col; prev_last = s_last;
      if (s_hs) begin
        checks++;
        if (!s_exp_ok) begin errors++; $display("FAIL rand_extra_block: got col %0d required none", s_col); end
        else if (s_data !== s_exp.data || s_col !== s_exp.col || s_last !== s_exp.last) begin
          errors++; $display("FAIL rand_block: got col %0d last %b data %h required col %0d last %b data %h", s_col, s_last, s_data, s_exp.col, s_exp.last, s_exp.data);
        end
        hs++;
      end
    end
    checks++; if (hs !== 4 * NC || expq.size() != 0) begin errors++; $display("FAIL rand_block_count: got %0d left %0d required %0d left 0", hs, expq.size(), 4 * NC); end
  endtask

  task automatic test_reset_mid_fetch();
    int hs = 0;
    do_reset(2);
    for (int t = 0; t < SP + 1000 && hs < 7; t++) begin
      step(1, 1'($urandom), 1);
      if (s_hs) begin
        checks++;
        if (!s_exp_ok || s_data !== s_exp.data || s_col !== s_exp.col) begin
          errors++; $display("FAIL midrst_pre_block: got col %0d data %h required col %0d data %h", s_col, s_data, s_exp.col, s_exp.data);
        end
        hs++;
      end
    end
    checks++; if (hs !== 7) begin errors++; $display("FAIL midrst_pre_count: got %0d required 7", hs); end
    step(1, 1'($urandom), 1);
    step(1, 1'($urandom), 1);
    reset_n = 1'b0;
    step(1, 1'($urandom), 1);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset: got %b required 0", s_ready); end
    reset_n = 1'b1;
    step(0, 0, 1);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_after: got %b required 0", s_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b required 1", s_ready); end
    hs = 0;
    for (int t = 0; t < SP + 1000 && hs < NC; t++) begin
      int p = acc_total;
      step(acc_total < SP, 1'(((p % FW) + (p / FW) + 1) % 2), 1);
      if (s_hs) begin
        checks++;
        if (!s_exp_ok) begin errors++; $display("FAIL midrst_extra_block: got col %0d required none", s_col); end
        else if (s_data !== s_exp.data || s_col !== s_exp.col || s_last !== s_exp.last) begin
          errors++; $display("FAIL midrst_block: got col %0d last %b data %h required col %0d last %b data %h", s_col, s_last, s_data, s_exp.col, s_exp.last, s_exp.data);
        end
        if (hs == 0) begin
          checks++; if (s_col !== 4'd0) begin errors++; $display("FAIL midrst_first_col: got %0d required 0", s_col); end
        end
        hs++;
      end
    end
    checks++; if (hs !== NC) begin errors++; $display("FAIL midrst_block_count: got %0d required %0d", hs, NC); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_acc_cyc = 0;
    pix_cnt = 0; strips_done = 0; strips_consumed = 0; acc_total = 0;
    reset_n = 1'b0; pix_in = 1'b0; pix_valid = 1'b0; blk_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_checker_strip();
    test_single_pixel();
    test_backpressure();
    test_random();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_to_blocks.md
STREAM_TO_BLOCKS -- requirements
Module: stream_to_blocks

Interface
REQ-001 SHALL have parameter blk_w, default 16, block width in pixels.
REQ-002 SHALL have parameter blk_h, default 16, block height in pixels.
REQ-003 SHALL have parameter frame_w, default 240, frame width in pixels, integer multiple of blk_w.
REQ-004 SHALL have parameter blk_size, default blk_w*blk_h, output block vector width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port pix_in  input  1  raster binary pixel, left-to-right, top-to-bottom.
REQ-008 SHALL have port pix_valid  input  1  pix_in qualifier.
REQ-009 SHALL have port pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
REQ-010 SHALL have port blk_data  output  blk_size  assembled block; row r at bits [r*blk_w +: blk_w], column c at bit c of that row.
REQ-011 SHALL have port blk_col  output  $clog2(frame_w/blk_w)  block column index of blk_data.
REQ-012 SHALL have port blk_last  output  1  high with the last block column of a strip.
REQ-013 SHALL have port blk_valid  output  1  blk_data/blk_col/blk_last qualifier.
REQ-014 SHALL have port blk_ready  input  1  block consumed when blk_valid && blk_ready.

Function
REQ-015 SHALL store pixels in two ping-pong strip buffers, each frame_w x blk_h bits, organised as blk_w-bit words, word address {buf, row*(frame_w/blk_w)+col}.
REQ-016 SHALL shift accepted pixels into a blk_w-bit register, first pixel to bit 0, and write the word to the current write buffer on the cycle the blk_w-th pixel is accepted.
REQ-017 SHALL advance write column after each word; at last column wrap to 0 and advance write row; at row blk_h-1 last column wrap row to 0 and toggle write buffer.
REQ-018 SHALL track buffer occupancy with 2-bit write and read strip counters; full = (wr_cnt - rd_cnt == 2).
REQ-019 SHALL deassert pix_ready when full; pix_ready otherwise 1; a pixel offered while pix_ready=0 is not consumed.
REQ-020 SHALL run read FSM states IDLE, FETCH, PRESENT.
REQ-021 IDLE -> FETCH when rd_cnt != wr_cnt; read column starts at 0.
REQ-022 FETCH SHALL issue blk_h reads, one per cycle, rows 0..blk_h-1 of current read column, and place each registered read word into its row slot (1-cycle RAM latency).
REQ-023 FETCH -> PRESENT one cycle after the last read issues; blk_valid asserts on entry, blk_h+1 cycles after FETCH entry.
REQ-024 PRESENT SHALL hold blk_data, blk_col, blk_last stable while blk_valid && !blk_ready.
REQ-025 On handshake in PRESENT: if not last column, advance column and -> FETCH; if last column, increment rd_cnt and -> IDLE.
REQ-026 blk_last SHALL equal (blk_col == frame_w/blk_w - 1) while blk_valid.
REQ-027 Write into one buffer and read of the other buffer in the same cycle SHALL both proceed; write and read never target the same buffer.
REQ-028 Buffer freed by the final handshake SHALL be writable the next cycle (pix_ready returns to 1 the cycle after rd_cnt increments).
REQ-029 Counters and addresses SHALL wrap modulo their widths without error; no frame-height notion, strips continue indefinitely.

Reset
REQ-030 On reset_n=0 at a clock edge: blk_valid=0, blk_col=0, blk_last=0, pix_ready=0 during reset, counters/addresses/shift register=0, FSM=IDLE.
REQ-031 Reset mid-strip or mid-block SHALL discard all partial and buffered data; first cycle after release pix_ready=1; blk_data content need not be cleared.

Verification
REQ-032 Strip of 240x16 pixels, pixel = (x+y)&1, blk_ready=1 -> 15 blocks, blk_col 0..14, blk_last only on 14, each blk_data row r = 16'hAAAA if r even else 16'h5555 pattern per REQ-016, first blk_valid 17 cycles after FETCH entry.
REQ-033 Single pixel at x=37,y=5 set, rest 0 -> only block blk_col=2 nonzero, blk_data bit 5*16+5 =1.
REQ-034 blk_ready=0, feed 3 strips continuously -> pix_ready drops after strip 2 completes, held 0; block 0 of strip 1 stable; release blk_ready -> 45 blocks in order, no loss.
REQ-035 Random pix_valid and blk_ready toggling (50%) over 4 strips -> output matches reference model bit-exact, no duplicates.
REQ-036 Assert reset_n=0 for 1 cycle during FETCH of strip 1 col 7 -> blk_valid=0 next cycle, new strip after release emits from blk_col=0 with new data only.
